// File: rtl/gpio_controller.sv
// PicoBlaze port-mapped controller for an 8-pin gpio_bit bank: direction/data registers,
// input resync, per-pin edge detection into a W1C pending register, and an IRQ/ack handshake.
module gpio_controller #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic [7:0] gpio_oen,
  output logic [7:0] gpio_data_out,
  input  logic [7:0] gpio_data_in
);

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ASSERT,
    IRQ_WAIT_CLR
  } irq_state_e;

  irq_state_e state_q, state_d;

  logic [7:0] dout_q, dout_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] imask_q, imask_d;
  logic [7:0] iedge_q, iedge_d;
  logic [7:0] ipend_q, ipend_d;
  logic [7:0] s1_q, s1_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] dir_dly_q, dir_dly_d;
  logic [1:0] armed_q, armed_d;
  logic [7:0] in_port_q, in_port_d;

  logic       hit;
  logic       wr_en;
  logic [2:0] offset;
  logic [7:0] din;
  logic [7:0] rise;
  logic [7:0] fall;
  logic [7:0] evt;
  logic [7:0] clr;
  logic       any_pending;

  // Reads have no side effects, so the strobe is not needed.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  always_comb begin
    hit       = (port_id[7:3] == BASE_ADDR[7:3]);
    offset    = port_id[2:0];
    wr_en     = write_strobe & hit;

    din       = (dir_q & dout_q) | (~dir_q & s1_q);
    rise      = s1_q & ~prev_q;
    fall      = ~s1_q & prev_q;
    // dir_dly_q masks the cycle after output->input, when s1/prev still carry the held value.
    evt       = ((iedge_q & rise) | (~iedge_q & fall)) & ~dir_q & ~dir_dly_q
                & {8{armed_q == 2'd2}};
    clr       = (wr_en && offset == 3'd5) ? out_port : '0;

    dout_d    = (wr_en && offset == 3'd0) ? out_port : dout_q;
    dir_d     = (wr_en && offset == 3'd1) ? out_port : dir_q;
    imask_d   = (wr_en && offset == 3'd3) ? out_port : imask_q;
    iedge_d   = (wr_en && offset == 3'd4) ? out_port : iedge_q;
    ipend_d   = (ipend_q & ~clr) | evt;

    s1_d      = gpio_data_in;
    prev_d    = s1_q;
    dir_dly_d = dir_q;
    armed_d   = (armed_q == 2'd2) ? armed_q : armed_q + 2'd1;

    in_port_d = '0;
    if (hit) begin
      case (offset)
        3'd0:    in_port_d = dout_q;
        3'd1:    in_port_d = dir_q;
        3'd2:    in_port_d = din;
        3'd3:    in_port_d = imask_q;
        3'd4:    in_port_d = iedge_q;
        3'd5:    in_port_d = ipend_q;
        default: in_port_d = '0;
      endcase
    end
  end

  always_comb begin
    any_pending = |(ipend_q & imask_q);
    state_d     = state_q;
    interrupt   = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (any_pending) state_d = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        interrupt = 1'b1;
        if (!any_pending)       state_d = IRQ_IDLE;
        else if (interrupt_ack) state_d = IRQ_WAIT_CLR;
      end
      IRQ_WAIT_CLR: begin
        if (!any_pending) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IRQ_IDLE;
      dout_q    <= '0;
      dir_q     <= '0;
      imask_q   <= '0;
      iedge_q   <= '0;
      ipend_q   <= '0;
      s1_q      <= '0;
      prev_q    <= '0;
      dir_dly_q <= '0;
      armed_q   <= '0;
      in_port_q <= '0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      imask_q   <= imask_d;
      iedge_q   <= iedge_d;
      ipend_q   <= ipend_d;
      s1_q      <= s1_d;
      prev_q    <= prev_d;
      dir_dly_q <= dir_dly_d;
      armed_q   <= armed_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port       = in_port_q;
  assign gpio_oen      = dir_q;
  assign gpio_data_out = dout_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Bench for gpio_controller: directed scenarios against fixed values, then random traffic
// checked against a cycle-level behavioural model of the register/edge/IRQ rules.
module tb_gpio_controller;

  localparam logic [7:0] BASE = 8'h28;

  logic       clk;
  logic       rst_n;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] gpio_oen;
  logic [7:0] gpio_data_out;
  logic [7:0] gpio_data_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  gpio_controller #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .gpio_oen      (gpio_oen),
    .gpio_data_out (gpio_data_out),
    .gpio_data_in  (gpio_data_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: register file, last two pin samples, previous DIR, IRQ flags.
  logic [7:0]  m_dout, m_dir, m_imask, m_iedge, m_ipend, m_in_port;
  logic [7:0]  m_pin_last, m_pin_prev, m_dir_last;
  logic        m_irq, m_wait;
  int unsigned m_edges;

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_imask = '0; m_iedge = '0; m_ipend = '0; m_in_port = '0;
    m_pin_last = '0; m_pin_prev = '0; m_dir_last = '0;
    m_irq = 1'b0; m_wait = 1'b0; m_edges = 0;
  endtask

  task automatic model_step();
    logic       hit, any;
    logic [2:0] off;
    logic [7:0] din, evt, clr, rv;
    hit = (port_id[7:3] == BASE[7:3]);
    off = port_id[2:0];
    evt = '0;
    for (int i = 0; i < 8; i++) begin
      din[i] = m_dir[i] ? m_dout[i] : m_pin_last[i];
      if (m_edges >= 2 && !m_dir[i] && !m_dir_last[i]) begin
        if (m_iedge[i]) evt[i] = m_pin_last[i] && !m_pin_prev[i];
        else            evt[i] = !m_pin_last[i] && m_pin_prev[i];
      end
    end
    rv = '0;
    if (hit) begin
      case (off)
        3'd0: rv = m_dout;
        3'd1: rv = m_dir;
        3'd2: rv = din;
        3'd3: rv = m_imask;
        3'd4: rv = m_iedge;
        3'd5: rv = m_ipend;
        default: rv = '0;
      endcase
    end
    any = (m_ipend & m_imask) != 8'h00;
    if (m_wait) begin
      if (!any) m_wait = 1'b0;
    end else if (m_irq) begin
      if (!any) m_irq = 1'b0;
      else if (interrupt_ack) begin m_irq = 1'b0; m_wait = 1'b1; end
    end else if (any) begin
      m_irq = 1'b1;
    end
    clr = (write_strobe && hit && off == 3'd5) ? out_port : 8'h00;
    m_ipend = (m_ipend & ~clr) | evt;
    m_dir_last = m_dir;
    if (write_strobe && hit) begin
      if (off == 3'd0) m_dout  = out_port;
      if (off == 3'd1) m_dir   = out_port;
      if (off == 3'd3) m_imask = out_port;
      if (off == 3'd4) m_iedge = out_port;
    end
    m_pin_prev = m_pin_last;
    m_pin_last = gpio_data_in;
    if (m_edges < 10) m_edges++;
    m_in_port = rv;
  endtask

  // Inputs are changed at the falling edge; one call advances one rising edge.
  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] data);
    port_id = {BASE[7:3], off};
    out_port = data;
    write_strobe = 1'b1;
    cycle();
    write_strobe = 1'b0;
  endtask

  task automatic rd_addr(input logic [2:0] off);
    port_id = {BASE[7:3], off};
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    gpio_data_in = 8'hFF;
    rd_addr(3'd2);
    rst_n = 1'b0;
    model_reset();
    cycle(); cycle(); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rst_in_port: got %h want 00", in_port); end
    checks++; if (gpio_oen !== 8'h00) begin errors++; $display("FAIL rst_oen: got %h want 00", gpio_oen); end
    checks++; if (gpio_data_out !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", gpio_data_out); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", interrupt); end
    rst_n = 1'b1;
    repeat (10) cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL post_rst_irq: got %b want 0", interrupt); end
    checks++; if (gpio_oen !== 8'h00) begin errors++; $display("FAIL post_rst_oen: got %h want 00", gpio_oen); end
    rd_addr(3'd5); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL post_rst_ipend: got %h want 00", in_port); end
    rd_addr(3'd2); cycle();
    checks++; if (in_port !== 8'hFF) begin errors++; $display("FAIL post_rst_din: got %h want FF", in_port); end
  endtask

  task automatic test_dir_dout();
    wr(3'd1, 8'h0F);
    checks++; if (gpio_oen !== 8'h0F) begin errors++; $display("FAIL dir_write: got %h want 0F", gpio_oen); end
    wr(3'd0, 8'hA5);
    checks++; if (gpio_data_out !== 8'hA5) begin errors++; $display("FAIL dout_write: got %h want A5", gpio_data_out); end
    gpio_data_in = 8'h3C;
    rd_addr(3'd2); cycle(); cycle();
    checks++; if (in_port !== 8'h35) begin errors++; $display("FAIL din_mixed: got %h want 35", in_port); end
    rd_addr(3'd1); cycle();
    checks++; if (in_port !== 8'h0F) begin errors++; $display("FAIL dir_read: got %h want 0F", in_port); end
    rd_addr(3'd6); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL off6_read: got %h want 00", in_port); end
    port_id = 8'h01; cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL miss_read: got %h want 00", in_port); end
    wr(3'd2, 8'h00);
    rd_addr(3'd2); cycle();
    checks++; if (in_port !== 8'h35) begin errors++; $display("FAIL din_write_ignored: got %h want 35", in_port); end
    port_id = 8'h01; out_port = 8'hFF; write_strobe = 1'b1; cycle(); write_strobe = 1'b0;
    checks++; if (gpio_oen !== 8'h0F) begin errors++; $display("FAIL miss_write: got %h want 0F", gpio_oen); end
  endtask

  task automatic test_edge_irq();
    wr(3'd4, 8'h10);
    wr(3'd3, 8'h10);
    gpio_data_in = 8'h2C;
    cycle(); cycle(); cycle();
    wr(3'd5, 8'hFF);
    rd_addr(3'd5); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL edge_pre_ipend: got %h want 00", in_port); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL edge_pre_irq: got %b want 0", interrupt); end
    gpio_data_in = 8'h3C;
    cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL edge_irq_p1: got %b want 0", interrupt); end
    cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL edge_irq_p2: got %b want 0", interrupt); end
    cycle();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL edge_irq_p3: got %b want 1", interrupt); end
    checks++; if (in_port !== 8'h10) begin errors++; $display("FAIL edge_ipend_p2: got %h want 10", in_port); end
    gpio_data_in = 8'h2C;
    cycle(); cycle(); cycle();
    checks++; if (in_port !== 8'h10) begin errors++; $display("FAIL fall_on_rise_bit: got %h want 10", in_port); end
    gpio_data_in = 8'h0C;
    cycle(); cycle(); cycle();
    checks++; if (in_port !== 8'h30) begin errors++; $display("FAIL fall_on_fall_bit: got %h want 30", in_port); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL unmasked_keeps_irq: got %b want 1", interrupt); end
  endtask

  task automatic test_ack();
    ack_pulse();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b want 0", interrupt); end
    gpio_data_in = 8'h1C;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL wait_clr_no_reraise: cycle %0d got %b want 0", i, interrupt); end
    end
    checks++; if (in_port !== 8'h30) begin errors++; $display("FAIL wait_clr_ipend: got %h want 30", in_port); end
    wr(3'd5, 8'h10);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL clr_w0: got %b want 0", interrupt); end
    rd_addr(3'd5); cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL clr_w1: got %b want 0", interrupt); end
    checks++; if (in_port !== 8'h20) begin errors++; $display("FAIL clr_ipend: got %h want 20", in_port); end
    cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL clr_w2: got %b want 0", interrupt); end
    gpio_data_in = 8'h0C; cycle(); cycle();
    gpio_data_in = 8'h1C; cycle(); cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reraise_p2: got %b want 0", interrupt); end
    cycle();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL reraise_p3: got %b want 1", interrupt); end
    ack_pulse();
    wr(3'd5, 8'hFF);
    cycle(); cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_cleanup: got %b want 0", interrupt); end
  endtask

  task automatic test_set_wins();
    gpio_data_in = 8'h0C; cycle(); cycle();
    gpio_data_in = 8'h1C; cycle();
    rd_addr(3'd5); out_port = 8'h10; write_strobe = 1'b1; cycle(); write_strobe = 1'b0;
    cycle();
    checks++; if (in_port !== 8'h10) begin errors++; $display("FAIL set_wins_ipend: got %h want 10", in_port); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", interrupt); end
    ack_pulse();
    wr(3'd5, 8'h10);
    rd_addr(3'd5); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL w1c_plain: got %h want 00", in_port); end
    cycle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_dir_switch();
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h01);
    gpio_data_in = 8'h01;
    cycle(); cycle(); cycle();
    wr(3'd5, 8'hFF);
    rd_addr(3'd5); cycle();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL dirsw_pre: got %h want 00", in_port); end
    gpio_data_in = 8'h00;
    port_id = {BASE[7:3], 3'd1}; out_port = 8'h00; write_strobe = 1'b1; cycle(); write_strobe = 1'b0;
    checks++; if (gpio_oen !== 8'h00) begin errors++; $display("FAIL dirsw_oen: got %h want 00", gpio_oen); end
    rd_addr(3'd5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (in_port[0] !== 1'b0) begin errors++; $display("FAIL dirsw_blocked: cycle %0d got %b want 0", i, in_port[0]); end
    end
    gpio_data_in = 8'h01; cycle(); cycle(); cycle();
    gpio_data_in = 8'h00; cycle(); cycle(); cycle();
    checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL dirsw_real_fall: got %h want 01", in_port); end
  endtask

  task automatic test_async_reset();
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'h5A);
    rd_addr(3'd0); cycle();
    checks++; if (in_port !== 8'h5A) begin errors++; $display("FAIL async_pre: got %h want 5A", in_port); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (gpio_oen !== 8'h00) begin errors++; $display("FAIL async_oen: got %h want 00", gpio_oen); end
    checks++; if (gpio_data_out !== 8'h00) begin errors++; $display("FAIL async_dout: got %h want 00", gpio_data_out); end
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL async_in_port: got %h want 00", in_port); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    logic [7:0] flip;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) port_id = 8'($urandom);
      else port_id = {BASE[7:3], 3'($urandom_range(0, 7))};
      write_strobe = ($urandom_range(0, 3) == 0);
      read_strobe = ($urandom_range(0, 3) == 0);
      out_port = 8'($urandom);
      interrupt_ack = interrupt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      flip = '0;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 7) == 0);
      gpio_data_in = gpio_data_in ^ flip;
      cycle();
      checks++; if (in_port !== m_in_port) begin errors++; $display("FAIL rnd_in_port: cycle %0d got %h want %h", n, in_port, m_in_port); end
      checks++; if (interrupt !== m_irq) begin errors++; $display("FAIL rnd_irq: cycle %0d got %b want %b", n, interrupt, m_irq); end
      checks++; if (gpio_oen !== m_dir) begin errors++; $display("FAIL rnd_oen: cycle %0d got %h want %h", n, gpio_oen, m_dir); end
      checks++; if (gpio_data_out !== m_dout) begin errors++; $display("FAIL rnd_dout: cycle %0d got %h want %h", n, gpio_data_out, m_dout); end
    end
    write_strobe = 1'b0;
    interrupt_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    port_id = '0;
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    out_port = '0;
    interrupt_ack = 1'b0;
    gpio_data_in = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_dir_dout();
    test_edge_irq();
    test_ack();
    test_set_wins();
    test_dir_switch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
